// File: rtl/trig_period_meter_if.sv
// Result channel of the trigger period meter: measured period, qualifiers and
// the valid/ready handshake towards the consumer.
interface trig_period_meter_if #(
  parameter int CNT_W = 24
);
  logic [CNT_W-1:0] period_o;
  logic             sat_o;
  logic             valid_o;
  logic             ready_i;
  logic             overrun_o;

  modport master (
    output period_o,
    output sat_o,
    output valid_o,
    output overrun_o,
    input  ready_i
  );

  modport slave (
    input  period_o,
    input  sat_o,
    input  valid_o,
    input  overrun_o,
    output ready_i
  );
endinterface

// File: rtl/trig_period_meter.sv
// Measures clk cycles between consecutive rising edges of an asynchronous
// trigger, re-arms the upstream trigger and hands each period over valid/ready.
module trig_period_meter #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                trig_i,
  output logic                clr_o,
  trig_period_meter_if.master res
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   synced_prev_reg;
  logic                   edge_strobe_reg;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   sat_flag_reg, sat_flag_next;
  logic                   load;

  logic [CNT_W-1:0]       period_reg;
  logic                   sat_reg;
  logic                   valid_reg;
  logic                   overrun_reg;
  logic                   clr_reg;

  // The synchronizer keeps running while disabled so no stale edge appears on re-enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg        <= '0;
      synced_prev_reg <= 1'b0;
      edge_strobe_reg <= 1'b0;
    end else begin
      sync_reg        <= {sync_reg[SYNC_STAGES-2:0], trig_i};
      synced_prev_reg <= sync_reg[SYNC_STAGES-1];
      edge_strobe_reg <= sync_reg[SYNC_STAGES-1] & ~synced_prev_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      sat_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      sat_flag_reg <= sat_flag_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    sat_flag_next = sat_flag_reg;
    load          = 1'b0;
    if (!enable) begin
      state_next    = IDLE;
      cnt_next      = '0;
      sat_flag_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next    = ARMED;
          cnt_next      = '0;
          sat_flag_next = 1'b0;
        end
        ARMED: begin
          if (edge_strobe_reg) begin
            state_next    = MEASURE;
            cnt_next      = CNT_ONE;
            sat_flag_next = 1'b0;
          end
        end
        MEASURE: begin
          if (edge_strobe_reg) begin
            load          = 1'b1;
            cnt_next      = CNT_ONE;
            sat_flag_next = 1'b0;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_next      = cnt_reg + CNT_ONE;
            // Flag is raised on the step that lands on the saturation value.
            sat_flag_next = sat_flag_reg | (cnt_reg == CNT_MAX - CNT_ONE);
          end
        end
        default: begin
          state_next    = IDLE;
          cnt_next      = '0;
          sat_flag_next = 1'b0;
        end
      endcase
    end
  end

  // A load while a result is pending wins over acceptance; overrun only if it was not taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_reg  <= '0;
      sat_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      clr_reg     <= 1'b0;
    end else begin
      clr_reg <= load;
      if (!enable) begin
        valid_reg   <= 1'b0;
        overrun_reg <= 1'b0;
      end else if (load) begin
        period_reg <= cnt_reg;
        sat_reg    <= sat_flag_reg;
        valid_reg  <= 1'b1;
        if (valid_reg && !res.ready_i) begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && res.ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign clr_o         = clr_reg;
  assign res.period_o  = period_reg;
  assign res.sat_o     = sat_reg;
  assign res.valid_o   = valid_reg;
  assign res.overrun_o = overrun_reg;

endmodule

// File: tb/tb_trig_period_meter.sv
// Directed bench for trig_period_meter (CNT_W=8, SYNC_STAGES=2) with
// hand-computed periods, handshake, saturation, enable and reset scenarios.
module tb_trig_period_meter;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic enable = 1'b0;
  logic trig_i = 1'b0;
  logic clr_o;

  trig_period_meter_if #(.CNT_W(8)) bus ();

  trig_period_meter #(
    .CNT_W       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .reset  (rst_n),
    .enable (enable),
    .trig_i (trig_i),
    .clr_o  (clr_o),
    .res    (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Passive observation of pulse counts and the most recent presented result.
  int         clr_cnt      = 0;
  int         valid_cycles = 0;
  logic [7:0] last_period  = '0;
  logic       last_sat     = 1'b0;

  always @(negedge clk) begin
    if (clr_o) clr_cnt++;
    if (bus.valid_o) begin
      valid_cycles++;
      last_period = bus.period_o;
      last_sat    = bus.sat_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_gap(input int gap);
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int c0;
  int v0;

  initial begin
    bus.ready_i = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_period", 32'(bus.period_o), 0);
    check("rst_valid", 32'(bus.valid_o), 0);
    check("rst_overrun", 32'(bus.overrun_o), 0);
    check("rst_clr", 32'(clr_o), 0);
    check("rst_sat", 32'(bus.sat_o), 0);
    step();
    step();
    rst_n       = 1'b1;
    enable      = 1'b1;
    bus.ready_i = 1'b1;
    repeat (3) step();
    check("idle_valid", 32'(bus.valid_o), 0);

    // Pulses every 100 clk: first only arms, the next two report 100
    c0 = clr_cnt;
    v0 = valid_cycles;
    pulse_gap(100);
    check("arm_no_result", 32'(valid_cycles - v0), 0);
    pulse_gap(100);
    pulse_gap(100);
    check("p100_clr_pulses", 32'(clr_cnt - c0), 2);
    check("p100_valid_cycles", 32'(valid_cycles - v0), 2);
    check("p100_period", 32'(last_period), 100);
    check("p100_sat", 32'(last_sat), 0);

    // Latency: result visible SYNC_STAGES+2 edges after the trigger rises
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    step();
    step();
    check("lat_valid_early", 32'(bus.valid_o), 0);
    step();
    check("lat_valid", 32'(bus.valid_o), 1);
    check("lat_clr", 32'(clr_o), 1);
    check("lat_period", 32'(bus.period_o), 100);
    step();
    check("lat_valid_drop", 32'(bus.valid_o), 0);
    check("lat_clr_drop", 32'(clr_o), 0);

    // Saturation: 300 clk exceeds 8 bits, then 50 clk measures normally
    repeat (295) step();
    pulse_gap(50);
    check("sat_period", 32'(last_period), 255);
    check("sat_flag", 32'(last_sat), 1);
    pulse_gap(20);
    check("post_sat_period", 32'(last_period), 50);
    check("post_sat_flag", 32'(last_sat), 0);

    // Overrun: consumer stalled across two results of 20
    bus.ready_i = 1'b0;
    pulse_gap(20);
    check("ovr_first_valid", 32'(bus.valid_o), 1);
    check("ovr_first_overrun", 32'(bus.overrun_o), 0);
    check("ovr_first_period", 32'(bus.period_o), 20);
    pulse_gap(20);
    check("ovr_second_valid", 32'(bus.valid_o), 1);
    check("ovr_second_overrun", 32'(bus.overrun_o), 1);
    check("ovr_second_period", 32'(bus.period_o), 20);
    bus.ready_i = 1'b1;
    step();
    bus.ready_i = 1'b0;
    check("ovr_accept_valid", 32'(bus.valid_o), 0);
    check("ovr_sticky", 32'(bus.overrun_o), 1);

    // Enable drop with a pending result; edges while disabled are ignored
    pulse_gap(10);
    check("en_pending_valid", 32'(bus.valid_o), 1);
    check("en_pending_period", 32'(bus.period_o), 21);
    enable = 1'b0;
    step();
    check("en_drop_valid", 32'(bus.valid_o), 0);
    check("en_drop_overrun", 32'(bus.overrun_o), 0);
    check("en_drop_clr", 32'(clr_o), 0);
    c0 = clr_cnt;
    v0 = valid_cycles;
    pulse_gap(20);
    pulse_gap(20);
    check("dis_no_clr", 32'(clr_cnt - c0), 0);
    check("dis_no_valid", 32'(valid_cycles - v0), 0);
    check("dis_period_kept", 32'(bus.period_o), 21);

    // Acceptance in the same cycle a new result loads
    enable = 1'b1;
    repeat (3) step();
    pulse_gap(30);
    check("same_arm_valid", 32'(bus.valid_o), 0);
    pulse_gap(25);
    check("same_held_valid", 32'(bus.valid_o), 1);
    check("same_held_period", 32'(bus.period_o), 30);
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    step();
    step();
    bus.ready_i = 1'b1;
    step();
    check("same_valid", 32'(bus.valid_o), 1);
    check("same_overrun", 32'(bus.overrun_o), 0);
    check("same_period", 32'(bus.period_o), 25);
    step();
    check("same_accept_valid", 32'(bus.valid_o), 0);

    // Reset 40 clk into a 100 clk period
    repeat (21) step();
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    repeat (39) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_period", 32'(bus.period_o), 0);
    check("mid_rst_valid", 32'(bus.valid_o), 0);
    check("mid_rst_sat", 32'(bus.sat_o), 0);
    check("mid_rst_clr", 32'(clr_o), 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (57) step();
    c0 = clr_cnt;
    v0 = valid_cycles;
    pulse_gap(100);
    check("rearm_no_result", 32'(valid_cycles - v0), 0);
    check("rearm_no_clr", 32'(clr_cnt - c0), 0);
    pulse_gap(10);
    check("rearm_period", 32'(last_period), 100);
    check("rearm_valid_cycles", 32'(valid_cycles - v0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
